// File: rtl/eight_way_rr_arbiter.sv
// Eight-requester round-robin arbiter with hold-until-release grants.
// Optional hold timeout is compiled in with EIGHT_WAY_RR_ARBITER_TIMEOUT_EN.
module eight_way_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned NumReq = 8;
  localparam int unsigned IdxW   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     gnt_idx_q, gnt_idx_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic [NumReq-1:0]   gnt_q, gnt_d;
  logic                pick_hit_c;
  logic [IdxW-1:0]     pick_idx_c;
  logic [IdxW-1:0]     cand_c;

`ifdef EIGHT_WAY_RR_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = 8;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
`else
  logic [7:0]          unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

  // Rotating priority scan: first requester at or after ptr, wrapping mod 8.
  always_comb begin
    pick_hit_c = 1'b0;
    pick_idx_c = '0;
    cand_c     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_c = ptr_q + IdxW'(k);
      if (!pick_hit_c && req[cand_c]) begin
        pick_hit_c = 1'b1;
        pick_idx_c = cand_c;
      end
    end
  end

  // Next-state logic: grant from IDLE, hold or release (or revoke) in BUSY.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
`ifdef EIGHT_WAY_RR_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en && pick_hit_c) begin
          state_d     = BUSY;
          gnt_idx_d   = pick_idx_c;
          gnt_valid_d = 1'b1;
`ifdef EIGHT_WAY_RR_ARBITER_TIMEOUT_EN
          cnt_d       = CntW'(1);
`endif
        end
      end
      BUSY: begin
        if (!req[gnt_idx_q]) begin
          // Normal release wins over a coincident timeout.
          state_d     = IDLE;
          ptr_d       = gnt_idx_q + IdxW'(1);
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
`ifdef EIGHT_WAY_RR_ARBITER_TIMEOUT_EN
          cnt_d       = '0;
        end else if (cnt_q == CntW'(MAX_HOLD)) begin
          state_d     = IDLE;
          ptr_d       = gnt_idx_q + IdxW'(1);
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          timeout_d   = 1'b1;
        end else begin
          cnt_d       = cnt_q + CntW'(1);
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
    gnt_d = gnt_valid_d ? (NumReq'(1) << gnt_idx_d) : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
`ifdef EIGHT_WAY_RR_ARBITER_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_q       <= gnt_d;
`ifdef EIGHT_WAY_RR_ARBITER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
`ifdef EIGHT_WAY_RR_ARBITER_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_eight_way_rr_arbiter.sv
// Directed bench for eight_way_rr_arbiter (MAX_HOLD = 3).
module tb_eight_way_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  eight_way_rr_arbiter #(.MAX_HOLD(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs against hand-computed values.
  task automatic expect_out(input string tag, input logic [7:0] g_e,
                            input logic [2:0] i_e, input logic v_e, input logic t_e);
    logic [12:0] obs;
    logic [12:0] exp_v;
    obs   = {gnt, gnt_idx, gnt_valid, timeout};
    exp_v = {g_e, i_e, v_e, t_e};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed gnt=%h idx=%0d v=%b to=%b expected gnt=%h idx=%0d v=%b to=%b",
             tag, gnt, gnt_idx, gnt_valid, timeout, g_e, i_e, v_e, t_e);
    end
  endtask

  initial begin
    logic [7:0] one_hot;
    rst = 1'b1;
    en  = 1'b1;
    req = 8'hFF;

    // Reset holds everything at zero even with all requests asserted.
    tick();
    expect_out("reset0", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    expect_out("reset1", 8'h00, 3'd0, 1'b0, 1'b0);

    // First grant after reset goes to requester 0.
    rst = 1'b0;
    tick();
    expect_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

    // Rotation: drop granted bit for one cycle, expect idle then next index.
    for (int i = 0; i < 8; i++) begin
      one_hot = 8'h01 << i;
      req = 8'hFF & ~one_hot;
      tick();
      expect_out($sformatf("rot_idle%0d", i), 8'h00, 3'd0, 1'b0, 1'b0);
      req = 8'hFF;
      tick();
      one_hot = 8'h01 << ((i + 1) % 8);
      expect_out($sformatf("rot_gnt%0d", (i + 1) % 8), one_hot, 3'((i + 1) % 8), 1'b1, 1'b0);
    end

    // Wrap and skip: steer ptr to 6 via a grant/release of requester 5.
    req = 8'h20;
    tick();
    expect_out("wrap_rel0", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    expect_out("wrap_g5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    expect_out("wrap_rel5", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h05;
    tick();
    expect_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h04;
    tick();
    expect_out("skip_rel0", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h05;
    tick();
    expect_out("skip_g2", 8'h04, 3'd2, 1'b1, 1'b0);

    // Enable gating: no grant while en=0; en ignored during BUSY.
    req = 8'h00;
    tick();
    expect_out("en_rel2", 8'h00, 3'd0, 1'b0, 1'b0);
    en  = 1'b0;
    req = 8'h10;
    tick();
    expect_out("en_off0", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    expect_out("en_off1", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    expect_out("en_on_g4", 8'h10, 3'd4, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    expect_out("en_busy_hold", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h1F;
    tick();
    expect_out("en_busy_other", 8'h10, 3'd4, 1'b1, 1'b0);
    en  = 1'b1;
    req = 8'h00;
    tick();
    expect_out("en_rel4", 8'h00, 3'd0, 1'b0, 1'b0);

    // Reset mid-grant: drop on the reset edge, ptr returns to 0.
    req = 8'h08;
    tick();
    expect_out("mid_g3", 8'h08, 3'd3, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 8'h48;   // ptr=0 picks 3; a stale ptr of 4..6 would pick 6
    tick();
    expect_out("mid_regrant3", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    expect_out("mid_rel3", 8'h00, 3'd0, 1'b0, 1'b0);

    // Hold / timeout behaviour on requester 1 (ptr is now 4).
    req = 8'h02;
    tick();
    expect_out("hold_g1_c1", 8'h02, 3'd1, 1'b1, 1'b0);
`ifdef EIGHT_WAY_RR_ARBITER_TIMEOUT_EN
    tick();
    expect_out("to_c2", 8'h02, 3'd1, 1'b1, 1'b0);
    tick();
    expect_out("to_c3", 8'h02, 3'd1, 1'b1, 1'b0);
    tick();
    expect_out("to_revoke", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    expect_out("to_pulse_end", 8'h02, 3'd1, 1'b1, 1'b0);
    tick();
    expect_out("to2_c2", 8'h02, 3'd1, 1'b1, 1'b0);
    tick();
    expect_out("to2_c3", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    expect_out("to_release_prio", 8'h00, 3'd0, 1'b0, 1'b0);
`else
    for (int c = 0; c < 22; c++) begin
      tick();
      expect_out($sformatf("hold_c%0d", c + 2), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick();
    expect_out("hold_rel1", 8'h00, 3'd0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
